// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the LEGv8 multicycle control unit.
// Optional macro CTRL_EXCEPTION_EN adds the illegal-op exception path.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    R_WB      = 4'd3,
    MEM_ADDR  = 4'd4,
    MEM_READ  = 4'd5,
    LOAD_WB   = 4'd6,
    MEM_WRITE = 4'd7,
    CBZ_EXEC  = 4'd8,
    B_EXEC    = 4'd9,
    ILLEGAL   = 4'd10,
    HALT      = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CL_R, CL_LD, CL_ST, CL_CBZ, CL_B, CL_ILL
  } op_class_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASSB = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_EXC    = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg2loc;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       mem_to_reg;
`ifdef CTRL_EXCEPTION_EN
    logic       exc;
`endif
  } ctrl_t;

  // Moore output table, indexed by the state being entered
  function automatic ctrl_t moore(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PC_ALU;
      end
      DECODE: begin
        c.alu_src_b = SRCB_BR;
        c.alu_op    = ALU_ADD;
      end
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALU_FUNCT;
      end
      R_WB: c.reg_write = 1'b1;
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      MEM_READ: c.mem_read = 1'b1;
      LOAD_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WRITE: c.mem_write = 1'b1;
      CBZ_EXEC: begin
        c.reg2loc   = 1'b1;
        c.alu_op    = ALU_PASSB;
        c.alu_src_b = SRCB_REG;
        c.pc_src    = PC_ALUOUT;
      end
      B_EXEC: begin
        c.pc_src = PC_ALUOUT;
        c.pc_en  = 1'b1;
      end
`ifdef CTRL_EXCEPTION_EN
      ILLEGAL: begin
        c.pc_src = PC_EXC;
        c.pc_en  = 1'b1;
        c.exc    = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle FSM and the datapath.
// Optional macro CTRL_EXCEPTION_EN adds the exc strobe.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [10:0]      op;
  logic             zero;
  logic             mem_ready;
  logic             pc_en;
  logic             ir_en;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             reg2loc;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_src;
  logic             mem_to_reg;
  logic             mem_err;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;
`ifdef CTRL_EXCEPTION_EN
  logic             exc;
`endif

  modport master (
    input  op, zero, mem_ready,
    output pc_en, ir_en, mem_read, mem_write,
    output reg_write, reg2loc, alu_src_a,
    output alu_src_b, alu_op, pc_src,
    output mem_to_reg, mem_err, instr_count, state
`ifdef CTRL_EXCEPTION_EN
    , output exc
`endif
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_en, ir_en, mem_read, mem_write,
    input  reg_write, reg2loc, alu_src_a,
    input  alu_src_b, alu_op, pc_src,
    input  mem_to_reg, mem_err, instr_count, state
`ifdef CTRL_EXCEPTION_EN
    , input exc
`endif
  );

endinterface

// File: rtl/multicycle_ctrl_op_classify.sv
// Opcode classifier: instruction[31:21] -> instruction class.
// Unrecognised encodings fall into CL_ILL.
module op_classify
  import ctrl_pkg::*;
(
  input  logic [10:0] op,
  output op_class_t   cls
);

  // Exact matches for R/D formats, prefix matches for CB/B
  always_comb begin
    cls = CL_ILL;
    unique case (1'b1)
      (op == OP_ADD),
      (op == OP_SUB),
      (op == OP_AND),
      (op == OP_ORR):        cls = CL_R;
      (op == OP_LDUR):       cls = CL_LD;
      (op == OP_STUR):       cls = CL_ST;
      (op[10:3] == OP_CBZ):  cls = CL_CBZ;
      (op[10:5] == OP_B):    cls = CL_B;
      default:               cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle LEGv8 datapath.
// Optional macro CTRL_EXCEPTION_EN traps illegal ops to the vector.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  localparam int WW = $clog2(TIMEOUT + 1);

  state_t           st;
  state_t           nxt;
  ctrl_t            mo;
  op_class_t        cls;
  logic [WW-1:0]    wcnt;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             retire;
  logic             wait_st;
  logic             stall;
  logic             tmo;

  op_classify u_cls (
    .op  (bus.op),
    .cls (cls)
  );

  assign wait_st = (st == FETCH) || (st == MEM_READ) ||
                   (st == MEM_WRITE);
  assign stall   = wait_st && !bus.mem_ready;
  assign tmo     = stall && (wcnt == WW'(TIMEOUT));

  // Next-state selection and retire detection
  always_comb begin
    nxt    = st;
    retire = 1'b0;
    case (st)
      FETCH: if (bus.mem_ready) nxt = DECODE;
      DECODE: begin
        unique case (cls)
          CL_R:         nxt = EXEC_R;
          CL_LD, CL_ST: nxt = MEM_ADDR;
          CL_CBZ:       nxt = CBZ_EXEC;
          CL_B:         nxt = B_EXEC;
          default:      nxt = ILLEGAL;
        endcase
      end
      EXEC_R: nxt = R_WB;
      MEM_ADDR: nxt = (cls == CL_ST) ? MEM_WRITE : MEM_READ;
      MEM_READ: if (bus.mem_ready) nxt = LOAD_WB;
      MEM_WRITE: begin
        if (bus.mem_ready) begin
          nxt    = FETCH;
          retire = 1'b1;
        end
      end
      R_WB, LOAD_WB, CBZ_EXEC, B_EXEC: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      ILLEGAL: begin
        nxt = FETCH;
`ifdef CTRL_EXCEPTION_EN
        retire = 1'b0;
`else
        retire = 1'b1;
`endif
      end
      HALT: nxt = HALT;
      default: nxt = FETCH;
    endcase
    if (tmo) nxt = HALT;
  end

  // State, registered Moore outputs, wait timer and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st   <= FETCH;
      mo   <= moore(FETCH);
      wcnt <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      st <= nxt;
      mo <= moore(nxt);
      if (stall && !tmo) wcnt <= wcnt + 1'b1;
      else               wcnt <= '0;
      if (retire) cnt <= cnt + 1'b1;
      if (tmo)    err <= 1'b1;
    end
  end

  assign bus.pc_en = mo.pc_en ||
    (!reset && st == FETCH && bus.mem_ready) ||
    (!reset && st == CBZ_EXEC && bus.zero);
  assign bus.ir_en = !reset && st == FETCH &&
                     bus.mem_ready;
  assign bus.reg2loc = mo.reg2loc ||
    (st == DECODE && (cls == CL_ST || cls == CL_CBZ));

  assign bus.mem_read    = mo.mem_read;
  assign bus.mem_write   = mo.mem_write;
  assign bus.reg_write   = mo.reg_write;
  assign bus.alu_src_a   = mo.alu_src_a;
  assign bus.alu_src_b   = mo.alu_src_b;
  assign bus.alu_op      = mo.alu_op;
  assign bus.pc_src      = mo.pc_src;
  assign bus.mem_to_reg  = mo.mem_to_reg;
  assign bus.mem_err     = err;
  assign bus.instr_count = cnt;
  assign bus.state       = st;
`ifdef CTRL_EXCEPTION_EN
  assign bus.exc         = mo.exc;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl.
// Build with CTRL_EXCEPTION_EN to exercise the exception path.
module tb_multicycle_ctrl;

  localparam int CNT_W = 32;

  localparam int S_FETCH  = 0;
  localparam int S_DEC    = 1;
  localparam int S_EXR    = 2;
  localparam int S_RWB    = 3;
  localparam int S_MADDR  = 4;
  localparam int S_MRD    = 5;
  localparam int S_LWB    = 6;
  localparam int S_MWR    = 7;
  localparam int S_CBZ    = 8;
  localparam int S_B      = 9;
  localparam int S_ILL    = 10;
  localparam int S_HALT   = 11;

  localparam logic [10:0] I_ADD  = 11'b10001011000;
  localparam logic [10:0] I_SUB  = 11'b11001011000;
  localparam logic [10:0] I_AND  = 11'b10001010000;
  localparam logic [10:0] I_ORR  = 11'b10101010000;
  localparam logic [10:0] I_LDUR = 11'b11111000010;
  localparam logic [10:0] I_STUR = 11'b11111000000;
  localparam logic [10:0] I_CBZ  = 11'b10110100101;
  localparam logic [10:0] I_B    = 11'b00010110011;
  localparam logic [10:0] I_BAD  = 11'b11111111111;

`ifdef CTRL_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;
  bit   exp_err = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  multicycle_ctrl #(
    .TIMEOUT (15),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // 0=R 1=LD 2=ST 3=CBZ 4=B 5=illegal
  function automatic int op_kind(logic [10:0] o);
    if (o == I_ADD || o == I_SUB || o == I_AND ||
        o == I_ORR) return 0;
    if (o == I_LDUR) return 1;
    if (o == I_STUR) return 2;
    if (o[10:3] == 8'b10110100) return 3;
    if (o[10:5] == 6'b000101) return 4;
    return 5;
  endfunction

  // {pc_en,ir_en,mrd,mwr,rw,r2l,srca,srcb,aop,psrc,m2r}
  function automatic logic [13:0] expect_out(
    int st, bit rdy, bit zr, logic [10:0] o);
    logic pe, ie, mr, mw, rw, r2, sa, m2r;
    logic [1:0] sb, ao, ps;
    pe = 0; ie = 0; mr = 0; mw = 0; rw = 0;
    r2 = 0; sa = 0; m2r = 0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      S_FETCH: begin
        mr = 1; sb = 2'b01; pe = rdy; ie = rdy;
      end
      S_DEC: begin
        sb = 2'b11;
        r2 = (op_kind(o) == 2) || (op_kind(o) == 3);
      end
      S_EXR:   begin sa = 1; ao = 2'b10; end
      S_RWB:   rw = 1;
      S_MADDR: begin sa = 1; sb = 2'b10; end
      S_MRD:   mr = 1;
      S_LWB:   begin rw = 1; m2r = 1; end
      S_MWR:   mw = 1;
      S_CBZ: begin
        r2 = 1; ao = 2'b01; ps = 2'b01; pe = zr;
      end
      S_B:     begin ps = 2'b01; pe = 1; end
      S_ILL: if (EXC_EN) begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {pe, ie, mr, mw, rw, r2, sa, sb, ao, ps, m2r};
  endfunction

  // One cycle: drive inputs after negedge, compare before posedge
  task automatic step(int st, bit rdy, bit zr,
                      logic [10:0] o);
    logic [13:0] act;
    @(negedge clk);
    bus.mem_ready = rdy;
    bus.zero      = zr;
    bus.op        = o;
    #2;
    act = {bus.pc_en, bus.ir_en, bus.mem_read,
           bus.mem_write, bus.reg_write, bus.reg2loc,
           bus.alu_src_a, bus.alu_src_b, bus.alu_op,
           bus.pc_src, bus.mem_to_reg};
    chk("state", 64'(bus.state), 64'(st));
    chk("ctrl", 64'(act), 64'(expect_out(st, rdy, zr, o)));
    chk("count", 64'(bus.instr_count), 64'(exp_count));
    chk("mem_err", 64'(bus.mem_err), 64'(exp_err));
`ifdef CTRL_EXCEPTION_EN
    chk("exc", 64'(bus.exc), 64'(st == S_ILL));
`endif
  endtask

  task automatic run_instr(logic [10:0] o, int fst,
                           int mst, bit zr);
    int k;
    k = op_kind(o);
    for (int i = 0; i < fst; i++) step(S_FETCH, 0, 0, o);
    step(S_FETCH, 1, 0, o);
    step(S_DEC, 1, 0, o);
    case (k)
      0: begin
        step(S_EXR, 1, 0, o);
        step(S_RWB, 1, 0, o);
      end
      1: begin
        step(S_MADDR, 1, 0, o);
        for (int i = 0; i < mst; i++) step(S_MRD, 0, 0, o);
        step(S_MRD, 1, 0, o);
        step(S_LWB, 1, 0, o);
      end
      2: begin
        step(S_MADDR, 1, 0, o);
        for (int i = 0; i < mst; i++) step(S_MWR, 0, 0, o);
        step(S_MWR, 1, 0, o);
      end
      3: step(S_CBZ, 1, zr, o);
      4: step(S_B, 1, 0, o);
      default: step(S_ILL, 1, 0, o);
    endcase
    if (!(k == 5 && EXC_EN)) exp_count++;
  endtask

  task automatic pin_count(string name, int exp);
    @(posedge clk);
    #1;
    chk(name, 64'(bus.instr_count), 64'(exp));
  endtask

  initial begin
    bus.op        = I_ADD;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    reset         = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    chk("rst_state", 64'(bus.state), 64'(0));
    chk("rst_count", 64'(bus.instr_count), 64'(0));
    chk("rst_err", 64'(bus.mem_err), 64'(0));
    chk("rst_mem_read", 64'(bus.mem_read), 64'(1));
    chk("rst_srcb", 64'(bus.alu_src_b), 64'(1));
    chk("rst_pc_en", 64'(bus.pc_en), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr(I_ADD, 0, 0, 0);
    pin_count("add_count", 1);
    run_instr(I_LDUR, 0, 3, 0);
    pin_count("ldur_count", 2);
    run_instr(I_CBZ, 0, 0, 1);
    run_instr(I_CBZ, 0, 0, 0);
    pin_count("cbz_count", 4);
    run_instr(I_BAD, 0, 0, 0);
    pin_count("ill_count", EXC_EN ? 4 : 5);
    run_instr(I_B, 1, 0, 0);
    run_instr(I_ORR, 2, 0, 0);
    run_instr(I_SUB, 0, 0, 0);
    run_instr(I_AND, 0, 0, 0);
    run_instr(I_STUR, 0, 2, 0);

    // Reset while a store is waiting on memory
    step(S_FETCH, 1, 0, I_STUR);
    step(S_DEC, 1, 0, I_STUR);
    step(S_MADDR, 1, 0, I_STUR);
    step(S_MWR, 0, 0, I_STUR);
    #1 reset = 1'b1;
    #1;
    chk("abort_mem_write", 64'(bus.mem_write), 64'(0));
    chk("abort_state", 64'(bus.state), 64'(0));
    chk("abort_count", 64'(bus.instr_count), 64'(0));
    exp_count = 0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Ready arrives exactly on the last allowed wait cycle
    run_instr(I_ADD, 15, 0, 0);
    run_instr(I_LDUR, 0, 15, 0);
    pin_count("edge_count", 2);

    // Fetch never completes -> halt
    for (int i = 0; i < 16; i++) step(S_FETCH, 0, 0, I_ADD);
    exp_err = 1'b1;
    step(S_HALT, 0, 0, I_ADD);
    step(S_HALT, 1, 1, I_ADD);
    step(S_HALT, 1, 0, I_ADD);
    chk("halt_err", 64'(bus.mem_err), 64'(1));
    chk("halt_state", 64'(bus.state), 64'(11));
    #1 reset = 1'b1;
    #1;
    chk("clr_err", 64'(bus.mem_err), 64'(0));
    chk("clr_state", 64'(bus.state), 64'(0));
    exp_err = 1'b0;
    exp_count = 0;
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr(I_STUR, 1, 0, 0);
    pin_count("post_halt_count", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle variant of the LEGv8 datapath. Sequences the shared ALU, unified memory, register file and PC register (flopr, N=64) through FETCH/DECODE/EXECUTE/MEM/WB cycles. Waits on a memory ready handshake and counts retired instructions. Drives enables and mux selects only; it holds no datapath values.

Parameters:
TIMEOUT, 15, max cycles waited on mem_ready in a memory state before mem_err
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high; forces RESET values immediately
op  in  11  instruction[31:21] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pc_en  out  1  PC flopr write enable
ir_en  out  1  instruction register load
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write
reg2loc  out  1  read-port-2 selects Rt (1) or Rm (0)
alu_src_a  out  1  0=PC, 1=regA
alu_src_b  out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
alu_op  out  2  00=add, 01=pass B, 10=funct-decoded
pc_src  out  2  00=ALU result, 01=ALUOut, 10=exception vector
mem_to_reg  out  1  writeback selects memory data
mem_err  out  1  sticky memory-timeout flag
instr_count  out  CNT_W  retired instructions
state  out  4  current state encoding (debug)

Behaviour:
- Reset: state=FETCH, instr_count=0, mem_err=0, wait counter=0. All strobes 0 except FETCH Moore outputs; selects at FETCH values.
- Outputs are Moore per state. Exceptions are Mealy, gated by mem_ready/zero in the same cycle.
- FETCH: mem_read=1; alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_en=pc_en=mem_ready. Stay until mem_ready, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). reg2loc=1 for STUR/CBZ. Next state by op:
  - R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000) -> EXEC_R
  - LDUR 11111000010 / STUR 11111000000 -> MEM_ADDR
  - CBZ op[10:3]=10110100 -> CBZ_EXEC
  - B op[10:5]=000101 -> B_EXEC
  - other -> ILLEGAL
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
- R_WB: reg_write=1, mem_to_reg=0 -> FETCH, retire.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_READ (LDUR) or MEM_WRITE (STUR).
- MEM_READ: mem_read=1; on mem_ready -> LOAD_WB.
- LOAD_WB: reg_write=1, mem_to_reg=1 -> FETCH, retire.
- MEM_WRITE: mem_write=1; on mem_ready -> FETCH, retire.
- CBZ_EXEC: reg2loc=1, alu_op=01, alu_src_b=00; pc_src=01, pc_en=zero -> FETCH, retire.
- B_EXEC: pc_src=01, pc_en=1 -> FETCH, retire.
- ILLEGAL: see Optional Feature.
- Wait counter:
  - Clears on entering FETCH/MEM_READ/MEM_WRITE; increments each cycle there without mem_ready.
  - Count==TIMEOUT with mem_ready low -> HALT, mem_err=1.
  - mem_ready on the TIMEOUT cycle wins; normal advance.
- HALT: all strobes 0, stays until reset.
- instr_count: +1 on each retire transition; wraps modulo 2^CNT_W.
- Reset mid-instruction: aborts immediately. No strobe survives the reset edge.

Optional Feature:
Macro CTRL_EXCEPTION_EN.
- Defined: ILLEGAL drives pc_src=10, pc_en=1, exc output 1 (extra 1-bit port) for one cycle -> FETCH. No retire count.
- Undefined: ILLEGAL is a one-cycle NOP -> FETCH, counted as retired; exc port absent.

Decomposition:
- Package ctrl_pkg: state enum (FETCH, DECODE, EXEC_R, R_WB, MEM_ADDR, MEM_READ, LOAD_WB, MEM_WRITE, CBZ_EXEC, B_EXEC, ILLEGAL, HALT); opcode constants; alu_src_b/alu_op/pc_src encodings.
- Sub-module op_classify: combinational op -> class (R, LD, ST, CBZ, B, ILL).

Test Plan:
- Reset for 5 cycles, release; mem_ready=1 constant, op=ADD -> states FETCH,DECODE,EXEC_R,R_WB; reg_write=1 only in R_WB; instr_count=1 after 4 cycles.
- op=LDUR, mem_ready low 3 cycles in MEM_READ -> 3 stall cycles; mem_to_reg=reg_write=1 in LOAD_WB; total 8 cycles.
- op=CBZ with zero=1 then zero=0 -> pc_en=1,pc_src=01 in CBZ_EXEC first time, pc_en=0 second; count +2.
- mem_ready held low in FETCH, TIMEOUT=15 -> HALT after 16 cycles, mem_err=1, stays until reset, reset clears to 0.
- op=11111111111: with CTRL_EXCEPTION_EN -> exc=1, pc_src=10, count unchanged; without -> count +1.
- Assert reset mid MEM_WRITE -> mem_write drops same cycle, state=FETCH, instr_count=0.
